m_cp0: RTL and testbench

Coprocessor-0 exception/interrupt controller in the M stage of the 5-stage MIPS pipeline. It holds SR, Cause, EPC and PRId, and takes exception codes and delay-slot flags from M-stage pipeline registers. It samples the six external hardware interrupt lines and generates the single-cycle `Req` that flushes the pipeline and gates HILO, memory and register-file writes. It also services `mfc0`/`mtc0` and supplies the `eret` return address.

---
 rtl/m_cp0.sv | 101 ++++++++++
 tb/tb_m_cp0.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/m_cp0.sv
// rtl/m_cp0.sv - CP0 exception/interrupt controller for the M stage.
// Holds SR, Cause, EPC, PRId; raises a one-cycle Req for interrupts and exceptions.
module m_cp0 #(
  parameter logic [31:0] PRID = 32'h2022_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        WE,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr;
  logic [31:0] cause;

  assign sr    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
  assign Req     = int_req | exc_req;
  assign EPCOut  = epc_q;

  always_comb begin
    CP0Out = 32'h0;
    case (A1)
      5'd12:   CP0Out = sr;
      5'd13:   CP0Out = cause;
      5'd14:   CP0Out = epc_q;
      5'd15:   CP0Out = PRID;
      default: CP0Out = 32'h0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // Req discards any coincident mtc0/eret; the faulting instruction never commits.
    if (Req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      bd_d       = BDIn;
      epc_d      = BDIn ? (PC - 32'd4) : PC;
    end else if (WE) begin
      if (A2 == 5'd12) begin
        im_d  = DIn[15:10];
        exl_d = DIn[1];
        ie_d  = DIn[0];
      end else if (A2 == 5'd14) begin
        epc_d = DIn;
      end
    end else if (EXLClr) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'h0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'h0;
      exc_code_q <= 5'h0;
      epc_q      <= 32'h0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_m_cp0.sv
// tb/tb_m_cp0.sv - directed self-checking bench for m_cp0.
module tb_m_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn, PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        WE, EXLClr;
  logic [31:0] CP0Out, EPCOut;
  logic        Req;

  int n_checks = 0;
  int n_fail   = 0;

  m_cp0 dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .PC(PC),
    .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .WE(WE),
    .EXLClr(EXLClr), .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] num, input logic [31:0] exp);
    A1 = num;
    #1;
    check(tag, CP0Out, exp);
  endtask

  task automatic mtc0(input logic [4:0] num, input logic [31:0] data);
    WE = 1'b1; A2 = num; DIn = data;
    tick();
    WE = 1'b0;
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; PC = 32'h0; BDIn = 1'b0;
    ExcCodeIn = 5'd0; HWInt = 6'h3F; WE = 1'b0; EXLClr = 1'b0;

    for (int i = 0; i < 2; i++) begin
      tick();
      rd("reset_sr", 5'd12, 32'h0);
      rd("reset_cause", 5'd13, 32'h0);
      check("reset_epcout", EPCOut, 32'h0);
      check("reset_req", {31'h0, Req}, 32'h0);
    end
    reset = 1'b0; HWInt = 6'h0;

    // Interrupt
    mtc0(5'd12, 32'h0000_FC01);
    rd("sr_written", 5'd12, 32'h0000_FC01);
    HWInt = 6'b000100; PC = 32'h0000_3010; BDIn = 1'b0;
    #1 check("int_req", {31'h0, Req}, 32'h1);
    tick();
    check("int_req_once", {31'h0, Req}, 32'h0);
    rd("int_sr_exl", 5'd12, 32'h0000_FC03);
    rd("int_cause", 5'd13, 32'h0000_1000);
    check("int_epc", EPCOut, 32'h0000_3010);

    // eret with the interrupt still pending
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_FC01);
    check("eret_req", {31'h0, Req}, 32'h1);
    tick();
    HWInt = 6'h0;

    // Priority and masking
    ExcCodeIn = 5'd10;
    #1 check("exl_blocks_exc", {31'h0, Req}, 32'h0);
    ExcCodeIn = 5'd0;
    mtc0(5'd12, 32'h0000_FC01);
    HWInt = 6'b000001; ExcCodeIn = 5'd4; PC = 32'h0000_3020;
    #1 check("int_exc_req", {31'h0, Req}, 32'h1);
    tick();
    rd("int_over_exc_cause", 5'd13, 32'h0000_0400);
    ExcCodeIn = 5'd0; HWInt = 6'h0;
    mtc0(5'd12, 32'h0000_FC00);
    HWInt = 6'h3F;
    #1 check("ie0_no_req", {31'h0, Req}, 32'h0);
    HWInt = 6'h0;
    mtc0(5'd12, 32'h0000_F801);
    HWInt = 6'b000001;
    #1 check("im_clear_no_req", {31'h0, Req}, 32'h0);
    HWInt = 6'h0;

    // Write/Req collision
    ExcCodeIn = 5'd8; PC = 32'h0000_3100; BDIn = 1'b0;
    WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEC;
    #1 check("coll_req", {31'h0, Req}, 32'h1);
    tick();
    WE = 1'b0; ExcCodeIn = 5'd0;
    check("coll_epc", EPCOut, 32'h0000_3100);
    rd("coll_cause", 5'd13, 32'h0000_0020);
    mtc0(5'd12, 32'h0);
    WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEC;
    rd("no_forward", 5'd14, 32'h0000_3100);
    tick();
    WE = 1'b0;
    rd("epc_written", 5'd14, 32'hDEAD_BEEC);

    // Exception in delay slot
    ExcCodeIn = 5'd12; BDIn = 1'b1; PC = 32'h0000_3008;
    #1 check("ds_req", {31'h0, Req}, 32'h1);
    tick();
    check("ds_epc", EPCOut, 32'h0000_3004);
    rd("ds_cause", 5'd13, 32'h8000_0030);
    ExcCodeIn = 5'd0;
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

    // PC wrap with BD, and single-cycle Req for a held fault
    ExcCodeIn = 5'd1; BDIn = 1'b1; PC = 32'h0;
    tick();
    check("wrap_epc", EPCOut, 32'hFFFF_FFFC);
    check("held_fault_req", {31'h0, Req}, 32'h0);
    ExcCodeIn = 5'd0; BDIn = 1'b0;

    // PRId and unimplemented registers
    rd("prid", 5'd15, 32'h2022_0007);
    mtc0(5'd15, 32'h0);
    rd("prid_ro", 5'd15, 32'h2022_0007);
    rd("unimpl", 5'd7, 32'h0);

    // WE beats EXLClr
    WE = 1'b1; EXLClr = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234;
    tick();
    WE = 1'b0; EXLClr = 1'b0;
    rd("we_wins_sr", 5'd12, 32'h0000_0002);
    check("we_wins_epc", EPCOut, 32'h0000_1234);

    // Reset mid-handler
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("midreset_sr", 5'd12, 32'h0);
    check("midreset_epc", EPCOut, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
